// File: rtl/life_pkg.sv
// Shared types and default widths for the Game of Life generation scheduler.
package life_pkg;

    localparam int unsigned FRAMES_PER_GEN_DEF = 30;
    localparam int unsigned ADDR_W             = 10;
    localparam int unsigned GEN_W              = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RUN,
        SWAP
    } state_t;

endpackage

// File: rtl/life_gen_sched_if.sv
// Cell-memory port bundle shared by the display fetch, the update engine and the arbiter.
interface life_gen_sched_if #(
    parameter int unsigned ADDR_W = life_pkg::ADDR_W
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              upd_req;
    logic [ADDR_W-1:0] upd_addr;
    logic              upd_we;
    logic              disp_gnt;
    logic              upd_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;

    // Requesters drive requests and observe grants and the muxed port.
    modport master (
        output disp_req, disp_addr, upd_req, upd_addr, upd_we,
        input  disp_gnt, upd_gnt, mem_addr, mem_we
    );

    // The scheduler arbitrates and drives the muxed port.
    modport slave (
        input  disp_req, disp_addr, upd_req, upd_addr, upd_we,
        output disp_gnt, upd_gnt, mem_addr, mem_we
    );
endinterface

// File: rtl/life_mem_arb.sv
// Fixed-priority single-port arbiter: display fetch first, update engine second.
module life_mem_arb #(
    parameter int unsigned ADDR_W = life_pkg::ADDR_W
) (
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              upd_req,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic              upd_we,
    output logic              disp_gnt,
    output logic              upd_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we
);

    // Display reads are never written back, so its grant forces we low.
    always_comb begin
        disp_gnt = 1'b0;
        upd_gnt  = 1'b0;
        mem_addr = '0;
        mem_we   = 1'b0;
        if (disp_req) begin
            disp_gnt = 1'b1;
            mem_addr = disp_addr;
        end else if (upd_req) begin
            upd_gnt  = 1'b1;
            mem_addr = upd_addr;
            mem_we   = upd_we;
        end
    end

endmodule

// File: rtl/life_gen_sched.sv
// Generation scheduler: vsync pacing, engine start/done handshake, tear-free buffer swap.
// Optional build macro LIFE_SCHED_WATCHDOG_EN adds a sticky wdog_err for a stalled engine.
module life_gen_sched #(
    parameter int unsigned FRAMES_PER_GEN = life_pkg::FRAMES_PER_GEN_DEF,
    parameter int unsigned ADDR_W         = life_pkg::ADDR_W,
    parameter int unsigned GEN_W          = life_pkg::GEN_W
) (
    input  logic             dclk,
    input  logic             clr,
    input  logic             vsync,
    input  logic             run,
    input  logic             step,
    input  logic             eng_done,
    life_gen_sched_if.slave  mem,
    output logic             eng_start,
    output logic             buf_sel,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy
`ifdef LIFE_SCHED_WATCHDOG_EN
    ,
    output logic             wdog_err
`endif
);
    import life_pkg::*;

    localparam int unsigned FC_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_GEN - 1);

    state_t            state, state_n;
    logic              vsync_q, tick;
    logic [FC_W-1:0]   frame_cnt;
    logic              fc_last;
    logic              step_pending, step_pending_n;
    logic              eng_start_n, buf_sel_n, busy_n, go_run;
    logic [GEN_W-1:0]  gen_count_n;
`ifdef LIFE_SCHED_WATCHDOG_EN
    logic [1:0]        wd_cnt, wd_cnt_n;
    logic              wdog_err_n;
`endif

    life_mem_arb #(.ADDR_W(ADDR_W)) u_arb (
        .disp_req  (mem.disp_req),
        .disp_addr (mem.disp_addr),
        .upd_req   (mem.upd_req),
        .upd_addr  (mem.upd_addr),
        .upd_we    (mem.upd_we),
        .disp_gnt  (mem.disp_gnt),
        .upd_gnt   (mem.upd_gnt),
        .mem_addr  (mem.mem_addr),
        .mem_we    (mem.mem_we)
    );

    // Frame tick: one-cycle pulse on the registered falling edge of vsync.
    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            vsync_q <= 1'b1;
            tick    <= 1'b0;
        end else begin
            vsync_q <= vsync;
            tick    <= vsync_q & ~vsync;
        end
    end

    assign fc_last = (frame_cnt == FC_LAST);

    always_ff @(posedge dclk or negedge clr) begin
        if (!clr)         frame_cnt <= '0;
        else if (!run)    frame_cnt <= '0;
        else if (tick)    frame_cnt <= fc_last ? '0 : frame_cnt + FC_W'(1);
    end

    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            state        <= IDLE;
            step_pending <= 1'b0;
            eng_start    <= 1'b0;
            buf_sel      <= 1'b0;
            gen_count    <= '0;
            busy         <= 1'b0;
`ifdef LIFE_SCHED_WATCHDOG_EN
            wd_cnt       <= '0;
            wdog_err     <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            step_pending <= step_pending_n;
            eng_start    <= eng_start_n;
            buf_sel      <= buf_sel_n;
            gen_count    <= gen_count_n;
            busy         <= busy_n;
`ifdef LIFE_SCHED_WATCHDOG_EN
            wd_cnt       <= wd_cnt_n;
            wdog_err     <= wdog_err_n;
`endif
        end
    end

    always_comb begin
        state_n        = state;
        step_pending_n = step_pending;
        eng_start_n    = 1'b0;
        buf_sel_n      = buf_sel;
        gen_count_n    = gen_count;
        busy_n         = busy;
        go_run         = 1'b0;
`ifdef LIFE_SCHED_WATCHDOG_EN
        wd_cnt_n       = wd_cnt;
        wdog_err_n     = wdog_err;
`endif
        // Steps are only latched while no generation is in flight.
        if (step && (state == IDLE || state == WAIT)) step_pending_n = 1'b1;

        case (state)
            IDLE: begin
                if (run)                        state_n = WAIT;
                else if (tick && step_pending)  go_run  = 1'b1;
            end
            WAIT: begin
                if (!run)                                     state_n = IDLE;
                else if (tick && (fc_last || step_pending))   go_run  = 1'b1;
            end
            RUN: begin
                if (eng_done) state_n = SWAP;
`ifdef LIFE_SCHED_WATCHDOG_EN
                else if (tick) begin
                    if (wd_cnt == 2'd3) begin
                        wdog_err_n = 1'b1;
                        busy_n     = 1'b0;
                        state_n    = IDLE;
                    end else begin
                        wd_cnt_n = wd_cnt + 2'd1;
                    end
                end
`endif
            end
            SWAP: begin
                // Swap only on a frame boundary so the display never tears.
                if (tick) begin
                    buf_sel_n   = ~buf_sel;
                    gen_count_n = gen_count + GEN_W'(1);
                    busy_n      = 1'b0;
                    state_n     = run ? WAIT : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (go_run) begin
            state_n        = RUN;
            eng_start_n    = 1'b1;
            busy_n         = 1'b1;
            step_pending_n = 1'b0;
`ifdef LIFE_SCHED_WATCHDOG_EN
            wd_cnt_n       = '0;
`endif
        end
    end

endmodule

// File: tb/tb_life_gen_sched.sv
// Scoreboard bench for life_gen_sched: engine-start and buffer-swap events checked against hand-built expectations.
module tb_life_gen_sched;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned GEN_W  = 16;

    logic             dclk = 1'b0;
    logic             clr = 1'b0;
    logic             vsync = 1'b1;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic             done_auto = 1'b0;
    logic             done_tick = 1'b0;
    logic             eng_done;
    logic             eng_start, buf_sel, busy;
    logic [GEN_W-1:0] gen_count;
`ifdef LIFE_SCHED_WATCHDOG_EN
    logic             wdog_err;
`endif

    assign eng_done = done_auto | done_tick;

    life_gen_sched_if #(.ADDR_W(ADDR_W)) mif ();

    life_gen_sched #(.FRAMES_PER_GEN(3), .ADDR_W(ADDR_W), .GEN_W(GEN_W)) dut (
        .dclk      (dclk),
        .clr       (clr),
        .vsync     (vsync),
        .run       (run),
        .step      (step),
        .eng_done  (eng_done),
        .mem       (mif.slave),
        .eng_start (eng_start),
        .buf_sel   (buf_sel),
        .gen_count (gen_count),
        .busy      (busy)
`ifdef LIFE_SCHED_WATCHDOG_EN
        ,
        .wdog_err  (wdog_err)
`endif
    );

    always #5 dclk = ~dclk;

    // kind: 1 = engine start, 0 = buffer swap; frame = vsync pulse number it belongs to
    typedef struct packed {
        logic             kind;
        logic [31:0]      frame;
        logic             bsel;
        logic [GEN_W-1:0] gen;
        logic             bsy;
    } ev_t;

    ev_t exp_q[$];
    int  frame_no  = 0;
    int  n_checks  = 0;
    int  n_errors  = 0;
    bit  auto_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge dclk);
        #1;
    endtask

    task automatic push(input logic k, input int f, input logic b, input int g, input logic bs);
        ev_t e;
        e.kind  = k;
        e.frame = 32'(f);
        e.bsel  = b;
        e.gen   = GEN_W'(g);
        e.bsy   = bs;
        exp_q.push_back(e);
    endtask

    // One 100-cycle video frame; optionally pulse eng_done exactly while the tick is high.
    task automatic frame(input bit done_on_tick);
        cyc();
        vsync = 1'b0;
        frame_no++;
        cyc();
        if (done_on_tick) done_tick = 1'b1;
        cyc();
        done_tick = 1'b0;
        repeat (2) cyc();
        vsync = 1'b1;
        repeat (95) cyc();
    endtask

    task automatic pulse_step();
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
    endtask

    task automatic observe(input logic k);
        ev_t act, exp;
        act.kind  = k;
        act.frame = 32'(frame_no);
        act.bsel  = buf_sel;
        act.gen   = gen_count;
        act.bsy   = busy;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: got kind=%0d frame=%0d buf=%0d gen=%0d busy=%0d, none expected",
                     act.kind, act.frame, act.bsel, act.gen, act.bsy);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_errors++;
                $display("FAIL event: got kind=%0d frame=%0d buf=%0d gen=%0d busy=%0d expected kind=%0d frame=%0d buf=%0d gen=%0d busy=%0d",
                         act.kind, act.frame, act.bsel, act.gen, act.bsy,
                         exp.kind, exp.frame, exp.bsel, exp.gen, exp.bsy);
            end
        end
    endtask

    // Monitor: every eng_start pulse and every buf_sel change outside reset is an event.
    initial begin
        logic prev_buf;
        prev_buf = 1'b0;
        forever begin
            @(negedge dclk);
            if (!clr) begin
                prev_buf = buf_sel;
            end else begin
                if (eng_start) observe(1'b1);
                if (buf_sel !== prev_buf) observe(1'b0);
                prev_buf = buf_sel;
            end
        end
    end

    // Engine model: done 20 cycles after each start when enabled.
    initial begin
        forever begin
            @(negedge dclk);
            if (eng_start && auto_done) begin
                repeat (20) @(posedge dclk);
                #1 done_auto = 1'b1;
                @(posedge dclk);
                #1 done_auto = 1'b0;
            end
        end
    end

    initial begin
        mif.disp_req  = 1'b0;
        mif.disp_addr = '0;
        mif.upd_req   = 1'b0;
        mif.upd_addr  = '0;
        mif.upd_we    = 1'b0;

        repeat (3) cyc();
        @(negedge dclk);
        chk("rst_buf_sel",   32'(buf_sel),   0);
        chk("rst_gen_count", 32'(gen_count), 0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_eng_start", 32'(eng_start), 0);
        chk("rst_disp_gnt",  32'(mif.disp_gnt), 0);
        chk("rst_upd_gnt",   32'(mif.upd_gnt),  0);
`ifdef LIFE_SCHED_WATCHDOG_EN
        chk("rst_wdog_err",  32'(wdog_err),  0);
`endif
        cyc();
        clr = 1'b1;
        repeat (3) cyc();

        // Free-run with 3 frames per generation: start on frames 3,6,9; swap on the following tick.
        auto_done = 1'b1;
        run = 1'b1;
        cyc();
        push(1, 3, 0, 0, 1);  push(0, 4, 1, 1, 0);
        push(1, 6, 1, 1, 1);  push(0, 7, 0, 2, 0);
        push(1, 9, 0, 2, 1);  push(0, 10, 1, 3, 0);
        repeat (10) frame(1'b0);
        run = 1'b0;
        repeat (3) cyc();
        chk("freerun_gen_count", 32'(gen_count), 3);
        chk("freerun_busy",      32'(busy),      0);

        // Single step; a second step while RUN is dropped.
        pulse_step();
        push(1, 11, 1, 3, 1);  push(0, 12, 0, 4, 0);
        fork
            frame(1'b0);
            begin
                repeat (10) cyc();
                step = 1'b1;
                cyc();
                step = 1'b0;
            end
        join
        repeat (3) frame(1'b0);
        chk("step_gen_count", 32'(gen_count), 4);
        chk("step_busy",      32'(busy),      0);

        // Arbitration priority.
        mif.disp_addr = 10'h155;
        mif.upd_addr  = 10'h2aa;
        mif.disp_req  = 1'b1;
        mif.upd_req   = 1'b1;
        mif.upd_we    = 1'b1;
        @(negedge dclk);
        chk("arb_both_disp_gnt", 32'(mif.disp_gnt), 1);
        chk("arb_both_upd_gnt",  32'(mif.upd_gnt),  0);
        chk("arb_both_mem_we",   32'(mif.mem_we),   0);
        chk("arb_both_mem_addr", 32'(mif.mem_addr), 32'h155);
        cyc();
        mif.disp_req = 1'b0;
        @(negedge dclk);
        chk("arb_upd_disp_gnt", 32'(mif.disp_gnt), 0);
        chk("arb_upd_upd_gnt",  32'(mif.upd_gnt),  1);
        chk("arb_upd_mem_we",   32'(mif.mem_we),   1);
        chk("arb_upd_mem_addr", 32'(mif.mem_addr), 32'h2aa);
        cyc();
        mif.upd_req = 1'b0;
        @(negedge dclk);
        chk("arb_none_upd_gnt",  32'(mif.upd_gnt),  0);
        chk("arb_none_mem_addr", 32'(mif.mem_addr), 0);
        chk("arb_none_mem_we",   32'(mif.mem_we),   0);
        cyc();
        mif.upd_we = 1'b0;

        // Done coincident with a tick: the swap waits for the next tick.
        auto_done = 1'b0;
        pulse_step();
        push(1, 15, 0, 4, 1);  push(0, 17, 1, 5, 0);
        frame(1'b0);
        frame(1'b1);
        chk("coinc_busy_before_swap", 32'(busy), 1);
        frame(1'b0);
        chk("coinc_gen_count", 32'(gen_count), 5);

        // Reset mid-generation, then normal pacing again.
        run = 1'b1;
        push(1, 20, 1, 5, 1);
        repeat (3) frame(1'b0);
        @(posedge dclk);
        #3 clr = 1'b0;
        #1;
        chk("clr_buf_sel",   32'(buf_sel),   0);
        chk("clr_gen_count", 32'(gen_count), 0);
        chk("clr_busy",      32'(busy),      0);
        chk("clr_eng_start", 32'(eng_start), 0);
        repeat (2) cyc();
        clr = 1'b1;
        auto_done = 1'b1;
        push(1, 23, 0, 0, 1);  push(0, 24, 1, 1, 0);
        repeat (4) frame(1'b0);
        run = 1'b0;
        repeat (3) cyc();
        chk("post_clr_gen_count", 32'(gen_count), 1);

`ifdef LIFE_SCHED_WATCHDOG_EN
        // Engine never finishes: error after the 4th tick spent in RUN.
        auto_done = 1'b0;
        pulse_step();
        push(1, 25, 1, 1, 1);
        repeat (4) frame(1'b0);
        chk("wdog_not_yet", 32'(wdog_err), 0);
        frame(1'b0);
        chk("wdog_err",       32'(wdog_err),  1);
        chk("wdog_busy",      32'(busy),      0);
        chk("wdog_gen_count", 32'(gen_count), 1);
        chk("wdog_buf_sel",   32'(buf_sel),   1);
`endif

        repeat (3) cyc();
        chk("expected_events_left", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
